// File: rtl/i2s_tdm_out.sv
// Multi-channel I2S / left-justified TDM serializer clocked by the bit clock.
// One frame is shifted out while at most one more waits in the pending register.
module i2s_tdm_out #(
  parameter int BITS_PRECISION = 24,
  parameter int SLOT_BITS      = 32,
  parameter int CHANNELS       = 2
) (
  input  logic                               sck,
  input  logic                               rst,
  input  logic [CHANNELS*BITS_PRECISION-1:0] frame_data,
  input  logic                               data_valid,
  output logic                               data_ready,
  input  logic                               mode,
  output logic                               ws,
  output logic                               sd,
  output logic                               underrun
);
  localparam int BW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int CW = $clog2(CHANNELS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(CHANNELS - 1);
  localparam logic [CW-1:0] SLOT_HALF = CW'(CHANNELS / 2);

  logic [BW-1:0] r_bitpos;
  logic [CW-1:0] r_slot;
  logic [CHANNELS-1:0][BITS_PRECISION-1:0] r_frame, r_pend;
  logic r_pend_full, r_mode_q, r_ws, r_sd, r_underrun;

  logic                      w_slot_end, w_load, w_take, w_ws;
  logic [CW-1:0]             w_nslot;
  logic [BITS_PRECISION-1:0] w_sample;
  logic [SLOT_BITS-1:0]      w_msbf;

  assign data_ready = !r_pend_full && !rst;
  assign w_take     = data_valid && data_ready;
  assign w_slot_end = (r_bitpos == BIT_LAST);
  assign w_load     = w_slot_end && (r_slot == SLOT_LAST);
  assign w_nslot    = w_slot_end ? ((r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1) : r_slot;
  // I2S looks one bit ahead so ws toggles one sck before the slot MSB.
  assign w_ws       = r_mode_q ? (r_slot >= SLOT_HALF) : (w_nslot >= SLOT_HALF);
  assign w_sample   = r_frame[r_slot];

  // w_msbf[b] is the bit that goes out at bit position b of the current slot.
  for (genvar i = 0; i < SLOT_BITS; i++) begin : g_bit
    if (i < BITS_PRECISION) begin : g_d
      assign w_msbf[i] = w_sample[BITS_PRECISION-1-i];
    end else begin : g_z
      assign w_msbf[i] = 1'b0;
    end
  end

  assign ws       = r_ws;
  assign sd       = r_sd;
  assign underrun = r_underrun;

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      r_bitpos    <= '0;
      r_slot      <= '0;
      r_frame     <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_mode_q    <= 1'b0;
      r_ws        <= 1'b0;
      r_sd        <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_bitpos   <= w_slot_end ? '0 : r_bitpos + 1'b1;
      r_slot     <= w_nslot;
      r_ws       <= w_ws;
      r_sd       <= w_msbf[r_bitpos];
      r_underrun <= 1'b0;
      if (w_load) begin
        r_mode_q <= mode;
        if (r_pend_full) begin
          r_frame     <= r_pend;
          r_pend_full <= 1'b0;
        end else if (data_valid) begin
          r_frame <= frame_data;
        end else begin
          r_frame    <= '0;
          r_underrun <= 1'b1;
        end
      end else if (w_take) begin
        r_pend      <= frame_data;
        r_pend_full <= 1'b1;
      end
    end
  end
endmodule
